// File: rtl/ave_pkg.sv
// Shared constants and width helpers for the streaming moving-average block.
// Optional build macro AVE_ROUND_EN (round-half-up output) is consumed by ave_n_stream.
package ave_pkg;

  // WARMUP modes: hold outputs until the window is full, or emit from the first sample
  localparam int AVE_WARMUP_SUPPRESS = 0;
  localparam int AVE_WARMUP_ZEROFILL = 1;

  // Running sum of N = 2^log2_n samples of w bits never exceeds w+log2_n bits
  function automatic int ave_sum_w(input int w, input int log2_n);
    return w + log2_n;
  endfunction

  // Fill count spans 0..N inclusive
  function automatic int ave_fill_w(input int log2_n);
    return log2_n + 1;
  endfunction

endpackage

// File: rtl/ave_ring_buf.sv
// Ring of N = 2^LOG2_N samples; exposes the entry at the write pointer, which is
// the oldest sample once the ring has been filled.
module ave_ring_buf
  import ave_pkg::*;
#(
  parameter int W      = 8,
  parameter int LOG2_N = 3
) (
  input  logic         CLOCK,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] oldest
);

  localparam int N = 1 << LOG2_N;

  logic [W-1:0]      mem_q [N];
  logic [LOG2_N-1:0] wp_q;
  logic [LOG2_N-1:0] wp_d;

  assign oldest = mem_q[wp_q];

  // Next write pointer: clear wins, otherwise advance on write (wraps at N by width)
  always_comb begin
    wp_d = wp_q;
    if (clr) begin
      wp_d = '0;
    end else if (wr_en) begin
      wp_d = wp_q + LOG2_N'(1);
    end
  end

  // Pointer register; storage is never cleared, stale entries are masked by the fill count
  always_ff @(posedge CLOCK) begin
    wp_q <= wp_d;
    if (wr_en && !clr) begin
      mem_q[wp_q] <= wr_data;
    end
  end

endmodule

// File: rtl/ave_n_stream.sv
// Streaming moving average over the last 2^LOG2_N unsigned samples with
// valid/ready on both sides and a one-deep registered output.
// Build macro AVE_ROUND_EN: round half up instead of truncating the average.
module ave_n_stream
  import ave_pkg::*;
#(
  parameter int W      = 8,
  parameter int LOG2_N = 3,
  parameter int WARMUP = 0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              flush,
  input  logic [W-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOG2_N:0]   fill_cnt
);

  localparam int N      = 1 << LOG2_N;
  localparam int SUM_W  = ave_sum_w(W, LOG2_N);
  localparam int FILL_W = ave_fill_w(LOG2_N);

  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q, out_data_d;

  logic              accept;
  logic              consume;
  logic              full;
  logic [W-1:0]      ring_oldest;
  logic [SUM_W-1:0]  oldest_ext;
  logic [SUM_W-1:0]  new_sum;
  logic [FILL_W-1:0] fill_inc;

  // Divide the window sum by N; rounding variant adds half an LSB of the result first
  function automatic logic [W-1:0] avg_f(input logic [SUM_W-1:0] s);
`ifdef AVE_ROUND_EN
    logic [SUM_W:0] half;
    logic [SUM_W:0] r;
    logic [SUM_W:0] max_v;
    half             = '0;
    half[LOG2_N-1]   = 1'b1;
    max_v            = '0;
    max_v[W-1:0]     = '1;
    r                = ({1'b0, s} + half) >> LOG2_N;
    if (r > max_v) begin
      return '1;
    end
    return r[W-1:0];
`else
    return W'(s >> LOG2_N);
`endif
  endfunction

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = out_valid_q && out_ready;
  assign full      = (fill_q == FILL_W'(N));

  // Oldest sample only leaves the sum once the window actually holds N samples;
  // the intermediate add may wrap but the subtraction brings it back in range
  assign oldest_ext = full ? SUM_W'(ring_oldest) : '0;
  assign new_sum    = sum_q + SUM_W'(in_data) - oldest_ext;
  assign fill_inc   = full ? fill_q : fill_q + FILL_W'(1);

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign fill_cnt  = fill_q;

  ave_ring_buf #(
    .W      (W),
    .LOG2_N (LOG2_N)
  ) u_ring (
    .CLOCK   (CLOCK),
    .clr     (RESET || flush),
    .wr_en   (accept),
    .wr_data (in_data),
    .oldest  (ring_oldest)
  );

  // Next-state for sum, fill count and the output register; flush discards everything pending
  always_comb begin
    sum_d       = sum_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      sum_d       = '0;
      fill_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      if (consume) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        sum_d  = new_sum;
        fill_d = fill_inc;
        if ((fill_inc == FILL_W'(N)) || (WARMUP == AVE_WARMUP_ZEROFILL)) begin
          out_valid_d = 1'b1;
          out_data_d  = avg_f(new_sum);
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sum_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_ave_n_stream.sv
// Self-checking bench for ave_n_stream (W=8, LOG2_N=3) in both WARMUP modes.
module tb_ave_n_stream;

  localparam int N = 8;
`ifdef AVE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic       clk;
  logic       rst;
  // Instance A: WARMUP=0
  logic       flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [7:0] in_data_a, out_data_a;
  logic [3:0] fill_a;
  // Instance B: WARMUP=1
  logic       flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [7:0] in_data_b, out_data_b;
  logic [3:0] fill_b;

  int checks;
  int failures;

  ave_n_stream #(.W(8), .LOG2_N(3), .WARMUP(0)) dut_a (
    .CLOCK(clk), .RESET(rst), .flush(flush_a),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .fill_cnt(fill_a)
  );

  ave_n_stream #(.W(8), .LOG2_N(3), .WARMUP(1)) dut_b (
    .CLOCK(clk), .RESET(rst), .flush(flush_b),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .fill_cnt(fill_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive A for one cycle, then settle just after the rising edge
  task automatic step_a(input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    flush_a = fl; in_valid_a = iv; in_data_a = d; out_ready_a = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic iv, input logic [7:0] d);
    @(negedge clk);
    in_valid_b = iv; in_data_b = d; out_ready_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reference average of a window sum, straight from the arithmetic definition
  function automatic int ref_avg(input int s);
    int r;
    if (RND) begin
      r = (s + N / 2) / N;
      if (r > 255) r = 255;
    end else begin
      r = s / N;
    end
    return r;
  endfunction

  typedef struct {
    logic [7:0] din;
    bit         ev;
    int         et;
    int         er;
    int         ef;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int q[$];
    bit mov;
    int mod;
    bit hold;
    logic ivld, ordy, fl, exp_ir, acc, cons;
    logic [7:0] idat;
    int s;
    int tr[8];
    int rr[8];

    checks = 0; failures = 0;
    rst = 1'b1;
    flush_a = 0; in_valid_a = 0; in_data_a = 0; out_ready_a = 1;
    flush_b = 0; in_valid_b = 0; in_data_b = 0; out_ready_b = 1;

    // Table: ramp 0..8 then eight 255s into a WARMUP=0 window
    tr = '{36, 67, 99, 130, 162, 193, 224, 255};
    rr = '{36, 68, 99, 131, 162, 193, 224, 255};
    for (int i = 0; i < 9; i++) begin
      tbl[i].din = 8'(i);
      tbl[i].ev  = (i >= 7);
      tbl[i].et  = (i == 7) ? 3 : (i == 8) ? 4 : 0;
      tbl[i].er  = (i == 7) ? 4 : (i == 8) ? 5 : 0;
      tbl[i].ef  = (i < 8) ? i + 1 : 8;
    end
    for (int k = 0; k < 8; k++) begin
      tbl[9 + k].din = 8'd255;
      tbl[9 + k].ev  = 1'b1;
      tbl[9 + k].et  = tr[k];
      tbl[9 + k].er  = rr[k];
      tbl[9 + k].ef  = 8;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid_a, 0);
    chk("reset_out_data", out_data_a, 0);
    chk("reset_fill", fill_a, 0);
    chk("reset_in_ready", in_ready_a, 1);
    @(negedge clk);
    rst = 1'b0;

    // WARMUP=1: zero-filled history
    step_b(1'b1, 8'd16);
    chk("warm_valid1", out_valid_b, 1);
    chk("warm_data1", out_data_b, 2);
    step_b(1'b1, 8'd16);
    chk("warm_valid2", out_valid_b, 1);
    chk("warm_data2", out_data_b, 4);
    chk("warm_fill2", fill_b, 2);
    step_b(1'b0, 8'd0);

    // Table-driven ramp and saturation-free 255 run
    for (int i = 0; i < 17; i++) begin
      step_a(1'b0, 1'b1, tbl[i].din, 1'b1);
      chk($sformatf("tbl%0d_valid", i), out_valid_a, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), out_data_a, RND ? tbl[i].er : tbl[i].et);
      chk($sformatf("tbl%0d_fill", i), fill_a, tbl[i].ef);
    end

    // Backpressure: output held, input stalled, source holds sample 0
    for (int c = 0; c < 5; c++) begin
      step_a(1'b0, 1'b1, 8'd0, 1'b0);
      chk("bp_in_ready", in_ready_a, 0);
      chk("bp_out_valid", out_valid_a, 1);
      chk("bp_out_data", out_data_a, 255);
      chk("bp_fill", fill_a, 8);
    end

    // Randomized stream against a window-queue model
    q.delete();
    for (int k = 0; k < 8; k++) q.push_back(255);
    mov = 1'b1; mod = 255; hold = 1'b1; ivld = 1'b1; idat = 8'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!hold) begin
        ivld = ($urandom_range(0, 3) != 0);
        idat = 8'($urandom);
      end
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      flush_a = fl; in_valid_a = ivld; in_data_a = idat; out_ready_a = ordy;
      #1;
      exp_ir = !mov || ordy;
      chk("rnd_in_ready", in_ready_a, exp_ir);
      chk("rnd_out_valid", out_valid_a, mov);
      chk("rnd_fill", fill_a, q.size());
      if (mov) chk("rnd_out_data", out_data_a, mod);
      acc  = ivld && exp_ir && !fl;
      cons = mov && ordy;
      hold = ivld && !exp_ir && !fl;
      @(posedge clk);
      if (fl) begin
        q.delete();
        mov = 1'b0;
      end else begin
        if (cons) mov = 1'b0;
        if (acc) begin
          q.push_back(int'(idat));
          if (q.size() > N) void'(q.pop_front());
          if (q.size() == N) begin
            s = 0;
            foreach (q[j]) s += q[j];
            mov = 1'b1;
            mod = ref_avg(s);
          end
        end
      end
    end

    // Flush with simultaneous sample at fill 5
    step_a(1'b1, 1'b0, 8'd0, 1'b1);
    for (int k = 0; k < 5; k++) step_a(1'b0, 1'b1, 8'd50, 1'b1);
    chk("pre_flush_fill", fill_a, 5);
    step_a(1'b1, 1'b1, 8'd99, 1'b1);
    chk("flush_fill", fill_a, 0);
    chk("flush_out_valid", out_valid_a, 0);
    chk("flush_in_ready", in_ready_a, 1);
    for (int k = 0; k < 8; k++) begin
      step_a(1'b0, 1'b1, 8'd10, 1'b1);
      chk("post_flush_valid", out_valid_a, (k == 7));
    end
    chk("post_flush_data", out_data_a, 10);
    chk("post_flush_fill", fill_a, 8);

    // Reset mid-stream with an unconsumed output
    @(negedge clk);
    rst = 1'b1; flush_a = 0; in_valid_a = 1; in_data_a = 8'd77; out_ready_a = 0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_fill", fill_a, 0);
    @(negedge clk);
    rst = 1'b0; in_valid_a = 0;
    for (int k = 0; k < 8; k++) begin
      step_a(1'b0, 1'b1, 8'd200, 1'b1);
      chk("post_rst_valid", out_valid_a, (k == 7));
    end
    chk("post_rst_data", out_data_a, 200);
    chk("post_rst_fill", fill_a, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
